// File: rtl/rsa_operand_loader.sv
// ---------------------------------------------------------------------------
// rsa_operand_loader
//
// Front-end issue block for the RSA modular-exponentiation core. It collects
// the plaintext M, the exponent E and the modulus N from a valid/ready word
// stream, in that order. It holds the three operands stable for the core and
// fires a one-cycle start pulse. Further input is blocked until the core
// returns its end-of-computation flag.
//
// Optional feature (macro RSA_OPERAND_CHECK_EN):
//   When defined, the operand set is validated at the N handshake. An even
//   modulus (including 0), a modulus of 1, or M >= N rejects the set. A
//   rejected set raises err, does not launch the core, and returns to
//   waiting for a new M. err clears on the next accepted M word. When the
//   macro is undefined there is no check logic and err is tied low.
//
// Ports:
//   clk       in   system clock, all state on rising edge
//   rstb      in   synchronous active-low reset
//   en        in   global clock-enable; when low all state and outputs hold
//   in_valid  in   host presents a word on in_data
//   in_data   in   operand word (M, then E, then N)
//   in_ready  out  loader accepts the word this cycle
//   eoc       in   end-of-computation from the core
//   M_o       out  registered plaintext to core
//   E_o       out  registered exponent to core
//   N_o       out  registered modulus to core
//   start     out  one-cycle launch pulse to core
//   busy      out  computation launched and not yet finished
//   err       out  last operand set rejected (check feature only)
// ---------------------------------------------------------------------------
module rsa_operand_loader #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             eoc,
    output logic [WIDTH-1:0] M_o,
    output logic [WIDTH-1:0] E_o,
    output logic [WIDTH-1:0] N_o,
    output logic             start,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        S_M     = 3'd0,
        S_E     = 3'd1,
        S_N     = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic             loading;
    logic             accept;
    logic             nReject;

    // The outputs are gated by rstb so that they read 0 during the reset
    // cycle itself, not only after the reset edge has been taken.
    assign loading  = (state_q == S_M) || (state_q == S_E) || (state_q == S_N);
    assign in_ready = rstb & en & loading;
    assign start    = rstb & en & (state_q == S_START);
    assign busy     = rstb & ((state_q == S_START) || (state_q == S_WAIT));
    assign accept   = in_valid & in_ready;

    assign M_o = m_q;
    assign E_o = e_q;
    assign N_o = n_q;

`ifdef RSA_OPERAND_CHECK_EN
    logic err_q, err_d;

    // The candidate modulus is judged on the word being handed over, and
    // against the M already captured earlier in this set.
    assign nReject = ~in_data[0] | (in_data == WIDTH'(1)) | (m_q >= in_data);
    assign err     = err_q;
`else
    assign nReject = 1'b0;
    assign err     = 1'b0;
`endif

    // Next-state and operand capture. en does not appear here because it is
    // already folded into accept, and the register process below holds
    // everything whenever en is low.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        e_d     = e_q;
        n_d     = n_q;
`ifdef RSA_OPERAND_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_M: begin
                if (accept) begin
                    m_d     = in_data;
                    state_d = S_E;
`ifdef RSA_OPERAND_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_E: begin
                if (accept) begin
                    e_d     = in_data;
                    state_d = S_N;
                end
            end
            S_N: begin
                if (accept) begin
                    n_d = in_data;
                    if (nReject) begin
                        state_d = S_M;
`ifdef RSA_OPERAND_CHECK_EN
                        err_d   = 1'b1;
`endif
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                // eoc is deliberately ignored here, even if the core raises
                // it in the same cycle as start.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eoc) begin
                    state_d = S_M;
                end
            end
            default: begin
                state_d = S_M;
            end
        endcase
    end

    // State and operand registers. Reset abandons any run in progress;
    // en low freezes every register.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= S_M;
            m_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
        end else if (en) begin
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            n_q     <= n_d;
        end
    end

`ifdef RSA_OPERAND_CHECK_EN
    // Rejection flag, held in the same clock-enable domain as the state.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            err_q <= 1'b0;
        end else if (en) begin
            err_q <= err_d;
        end
    end
`endif

endmodule
